// File: rtl/vga_render_if.sv
// vga_render_if: game-state snapshot inputs and VGA outputs of vga_render.
// master drives the game state and observes the picture; slave is the renderer.
interface vga_render_if;
    logic [15:0] bird_y;
    logic [31:0] pipe1;
    logic [31:0] pipe2;
    logic [31:0] pipe3;
    logic [31:0] coin;
    logic [15:0] score;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        frame_tick;

    modport master (
        output bird_y, pipe1, pipe2, pipe3, coin, score,
        input  hs, vs, r, g, b, frame_tick
    );

    modport slave (
        input  bird_y, pipe1, pipe2, pipe3, coin, score,
        output hs, vs, r, g, b, frame_tick
    );
endinterface

// File: rtl/vga_render.sv
// vga_render: 640x480@60 VGA timing and scene rasteriser (bird, pipes, coin, sky).
// Game state is snapshotted once per frame at vertical-blank entry (hc=0, vc=480).
// Two-stage pixel pipeline: stage 1 registers hit tests, stage 2 registers colour.
// Optional build macro SCORE_OVERLAY_EN draws the snapshotted score as 4 hex digits.
module vga_render #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned BIRD_X  = 40,
    parameter int unsigned BIRD_W  = 16,
    parameter int unsigned BIRD_H  = 16,
    parameter int unsigned PIPE_W  = 50,
    parameter int unsigned COIN_L  = 16
) (
    input logic         clk,
    input logic         rst,
    vga_render_if.slave bus
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [11:0] COL_OVL  = 12'hFFF;
    localparam logic [11:0] COL_BIRD = 12'hFD0;
    localparam logic [11:0] COL_COIN = 12'hFA0;
    localparam logic [11:0] COL_PIPE = 12'h0C0;
    localparam logic [11:0] COL_SKY  = 12'h4CF;

    logic [DIV_W-1:0] div_q;
    logic [9:0]       hc_q;
    logic [9:0]       vc_q;
    logic             pe;
    logic             snap;

    // Shadow copy of the game state, valid for the whole next frame
    logic [9:0] sh_by;
    logic [9:0] sh_px  [3];
    logic [9:0] sh_py  [3];
    logic [7:0] sh_gap [3];
    logic       sh_cv;
    logic [9:0] sh_cx;
    logic [9:0] sh_cy;

    logic [31:0] pipe_in [3];

    logic        hit_bird, hit_coin, hit_pipe, hit_ovl;
    logic        vis_c, hs_c, vs_c;
    logic        s1_bird, s1_coin, s1_pipe, s1_ovl, s1_vis, s1_hs, s1_vs;
    logic        hs_q, vs_q;
    logic [11:0] rgb_q, rgb_c;
    logic [10:0] x, gy;

    assign pe   = (div_q == DIV_MAX);
    assign snap = pe && (hc_q == 10'd0) && (vc_q == 10'd480);
    assign x    = {1'b0, hc_q};
    // Game y grows upward; wraps outside the visible rows, which are blanked anyway
    assign gy   = 11'd479 - {1'b0, vc_q};

    assign pipe_in[0] = bus.pipe1;
    assign pipe_in[1] = bus.pipe2;
    assign pipe_in[2] = bus.pipe3;

    // Pixel-rate divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (pe) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Horizontal and vertical raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else if (pe) begin
            if (hc_q == 10'd799) begin
                hc_q <= '0;
                vc_q <= (vc_q == 10'd524) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_q <= hc_q + 10'd1;
            end
        end
    end

    // Once-per-frame snapshot of the game state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_by <= '0;
            sh_cv <= 1'b0;
            sh_cx <= '0;
            sh_cy <= '0;
            for (int k = 0; k < 3; k++) begin
                sh_px[k]  <= '0;
                sh_py[k]  <= '0;
                sh_gap[k] <= '0;
            end
        end else if (snap) begin
            sh_by <= bus.bird_y[9:0];
            sh_cv <= bus.coin[31];
            sh_cy <= bus.coin[19:10];
            sh_cx <= bus.coin[9:0];
            for (int k = 0; k < 3; k++) begin
                sh_gap[k] <= pipe_in[k][27:20];
                sh_px[k]  <= pipe_in[k][19:10];
                sh_py[k]  <= pipe_in[k][9:0];
            end
        end
    end

`ifdef SCORE_OVERLAY_EN
    logic [15:0] sh_score;
    logic [9:0]  ox, oy;
    logic [3:0]  nib;
    logic [14:0] dots;
    logic [2:0]  row_bits;

    // 3x5 hex font, rows top to bottom, leftmost dot in the MSB of each row
    function automatic logic [14:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 15'b111_101_101_101_111;
            4'h1:    glyph = 15'b010_110_010_010_111;
            4'h2:    glyph = 15'b111_001_111_100_111;
            4'h3:    glyph = 15'b111_001_111_001_111;
            4'h4:    glyph = 15'b101_101_111_001_001;
            4'h5:    glyph = 15'b111_100_111_001_111;
            4'h6:    glyph = 15'b111_100_111_101_111;
            4'h7:    glyph = 15'b111_001_001_001_001;
            4'h8:    glyph = 15'b111_101_111_101_111;
            4'h9:    glyph = 15'b111_101_111_001_111;
            4'hA:    glyph = 15'b111_101_111_101_101;
            4'hB:    glyph = 15'b110_101_110_101_110;
            4'hC:    glyph = 15'b111_100_100_100_111;
            4'hD:    glyph = 15'b110_101_101_101_110;
            4'hE:    glyph = 15'b111_100_111_100_111;
            default: glyph = 15'b111_100_111_100_100;
        endcase
    endfunction

    // Score shadow, taken with the rest of the game state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_score <= '0;
        end else if (snap) begin
            sh_score <= bus.score;
        end
    end

    // Font lookup for the 4-digit block at x=8..71, rows 8..27 (4x4 px per dot)
    always_comb begin
        ox       = hc_q - 10'd8;
        oy       = vc_q - 10'd8;
        hit_ovl  = 1'b0;
        nib      = 4'h0;
        dots     = '0;
        row_bits = '0;
        if (hc_q >= 10'd8 && hc_q < 10'd72 && ox[3:0] < 4'd12 &&
            vc_q >= 10'd8 && vc_q < 10'd28) begin
            case (ox[5:4])
                2'd0:    nib = sh_score[15:12];
                2'd1:    nib = sh_score[11:8];
                2'd2:    nib = sh_score[7:4];
                default: nib = sh_score[3:0];
            endcase
            dots = glyph(nib);
            case (oy[4:2])
                3'd0:    row_bits = dots[14:12];
                3'd1:    row_bits = dots[11:9];
                3'd2:    row_bits = dots[8:6];
                3'd3:    row_bits = dots[5:3];
                default: row_bits = dots[2:0];
            endcase
            case (ox[3:2])
                2'd0:    hit_ovl = row_bits[2];
                2'd1:    hit_ovl = row_bits[1];
                default: hit_ovl = row_bits[0];
            endcase
        end
    end

    logic unused_in;
    assign unused_in = ^{bus.bird_y[15:10], bus.pipe1[31:28], bus.pipe2[31:28],
                         bus.pipe3[31:28], bus.coin[30:20]};
`else
    assign hit_ovl = 1'b0;

    logic unused_in;
    assign unused_in = ^{bus.bird_y[15:10], bus.pipe1[31:28], bus.pipe2[31:28],
                         bus.pipe3[31:28], bus.coin[30:20], bus.score};
`endif

    // Stage 1 combinational hit tests; all sums are 11 bits so right edges never wrap
    always_comb begin
        hit_bird = (x >= 11'(BIRD_X)) && (x < 11'(BIRD_X + BIRD_W)) &&
                   (gy >= {1'b0, sh_by}) && (gy < {1'b0, sh_by} + 11'(BIRD_H));
        hit_coin = sh_cv && (x >= {1'b0, sh_cx}) && (x < {1'b0, sh_cx} + 11'(COIN_L)) &&
                   (gy >= {1'b0, sh_cy}) && (gy < {1'b0, sh_cy} + 11'(COIN_L));
        hit_pipe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (sh_px[k] < 10'd640 && x >= {1'b0, sh_px[k]} &&
                x < {1'b0, sh_px[k]} + 11'(PIPE_W) &&
                (gy <= {1'b0, sh_py[k]} || gy >= {1'b0, sh_py[k]} + {3'b000, sh_gap[k]})) begin
                hit_pipe = 1'b1;
            end
        end
        vis_c = (hc_q < 10'd640) && (vc_q < 10'd480);
        hs_c  = !(hc_q >= 10'd656 && hc_q <= 10'd751);
        vs_c  = !(vc_q == 10'd490 || vc_q == 10'd491);
    end

    // Stage 1 registers: hit flags plus sync/visible delayed alongside
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_bird <= 1'b0;
            s1_coin <= 1'b0;
            s1_pipe <= 1'b0;
            s1_ovl  <= 1'b0;
            s1_vis  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
        end else if (pe) begin
            s1_bird <= hit_bird;
            s1_coin <= hit_coin;
            s1_pipe <= hit_pipe;
            s1_ovl  <= hit_ovl;
            s1_vis  <= vis_c;
            s1_hs   <= hs_c;
            s1_vs   <= vs_c;
        end
    end

    // Colour priority: overlay > bird > coin > pipe > sky, black when blanked
    always_comb begin
        rgb_c = COL_SKY;
        if (!s1_vis) begin
            rgb_c = 12'h000;
        end else if (s1_ovl) begin
            rgb_c = COL_OVL;
        end else if (s1_bird) begin
            rgb_c = COL_BIRD;
        end else if (s1_coin) begin
            rgb_c = COL_COIN;
        end else if (s1_pipe) begin
            rgb_c = COL_PIPE;
        end
    end

    // Stage 2 registers: colour and syncs driven straight to the connector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else if (pe) begin
            hs_q  <= s1_hs;
            vs_q  <= s1_vs;
            rgb_q <= rgb_c;
        end
    end

    assign bus.hs         = hs_q;
    assign bus.vs         = vs_q;
    assign bus.r          = rgb_q[11:8];
    assign bus.g          = rgb_q[7:4];
    assign bus.b          = rgb_q[3:0];
    assign bus.frame_tick = snap;

endmodule

// File: tb/tb_vga_render.sv
// tb_vga_render: two renderers (1 clk/pixel for full frames, 4 clk/pixel for divider and
// mid-frame reset) checked every clock against a frame-arithmetic model of the picture.
module tb_vga_render;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m, rst_a;
    vga_render_if bus_m ();
    vga_render_if bus_a ();

    vga_render #(.CLK_DIV(1)) dut_m (.clk(clk), .rst(rst_m), .bus(bus_m));
    vga_render #(.CLK_DIV(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // Clock edges since reset release, per DUT
    int n_m, n_a;
    always @(posedge clk or negedge rst_m) if (!rst_m) n_m <= 0; else n_m <= n_m + 1;
    always @(posedge clk or negedge rst_a) if (!rst_a) n_a <= 0; else n_a <= n_a + 1;

    // Model copy of the frame state each DUT is displaying (index 0 = dut_m, 1 = dut_a)
    int sh_by[2], sh_cv[2], sh_cx[2], sh_cy[2], sh_sc[2];
    int sh_px[2][3], sh_py[2][3], sh_gap[2][3];

    // Literal expectations for dut_m keyed by n*4+kind (0 rgb, 1 hs, 2 vs, 3 tick)
    int lit[int];

    localparam int FRAME = 800 * 525;
    localparam int SNAP  = 480 * 800;
    localparam int F1    = FRAME;

    task automatic finish_run();
        if (!done) begin
            done = 1'b1;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    task automatic clear_shadow(input int d);
        sh_by[d] = 0; sh_cv[d] = 0; sh_cx[d] = 0; sh_cy[d] = 0; sh_sc[d] = 0;
        for (int k = 0; k < 3; k++) begin
            sh_px[d][k] = 0; sh_py[d][k] = 0; sh_gap[d][k] = 0;
        end
    endtask

    task automatic take_snapshot(input int d, input logic [15:0] by, input logic [31:0] p1,
                                 input logic [31:0] p2, input logic [31:0] p3,
                                 input logic [31:0] cn, input logic [15:0] sc);
        logic [31:0] p [3];
        p[0] = p1; p[1] = p2; p[2] = p3;
        sh_by[d] = int'(by[9:0]);
        sh_cv[d] = int'(cn[31]);
        sh_cy[d] = int'(cn[19:10]);
        sh_cx[d] = int'(cn[9:0]);
        sh_sc[d] = int'(sc);
        for (int k = 0; k < 3; k++) begin
            sh_gap[d][k] = int'(p[k][27:20]);
            sh_px[d][k]  = int'(p[k][19:10]);
            sh_py[d][k]  = int'(p[k][9:0]);
        end
    endtask

`ifdef SCORE_OVERLAY_EN
    // Expected digit shapes for the glyphs this bench displays (0..4)
    function automatic bit ovl_dot(input int d, input int x, input int y);
        int i, ox, row, col, nib, g;
        if (x < 8 || x >= 72 || y < 8 || y >= 28) return 1'b0;
        i  = (x - 8) / 16;
        ox = (x - 8) % 16;
        if (ox >= 12) return 1'b0;
        col = ox / 4;
        row = (y - 8) / 4;
        nib = (sh_sc[d] >> (12 - 4 * i)) & 15;
        case (nib)
            0:       g = 'b111_101_101_101_111;
            1:       g = 'b010_110_010_010_111;
            2:       g = 'b111_001_111_100_111;
            3:       g = 'b111_001_111_001_111;
            4:       g = 'b101_101_111_001_001;
            default: g = 0;
        endcase
        return ((g >> (14 - 3 * row - col)) & 1) != 0;
    endfunction
`endif

    function automatic logic [11:0] colour(input int d, input int x, input int y);
        int gy;
        if (x >= 640 || y >= 480) return 12'h000;
        gy = 479 - y;
`ifdef SCORE_OVERLAY_EN
        if (ovl_dot(d, x, y)) return 12'hFFF;
`endif
        if (x >= 40 && x < 56 && gy >= sh_by[d] && gy < sh_by[d] + 16) return 12'hFD0;
        if (sh_cv[d] != 0 && x >= sh_cx[d] && x < sh_cx[d] + 16 &&
            gy >= sh_cy[d] && gy < sh_cy[d] + 16) return 12'hFA0;
        for (int k = 0; k < 3; k++) begin
            if (sh_px[d][k] < 640 && x >= sh_px[d][k] && x < sh_px[d][k] + 50 &&
                (gy <= sh_py[d][k] || gy >= sh_py[d][k] + sh_gap[d][k])) return 12'h0C0;
        end
        return 12'h4CF;
    endfunction

    function automatic bit tick_exp(input int n, input int div);
        return (n % div == div - 1) && ((n / div) % FRAME == SNAP);
    endfunction

    // {hs, vs, frame_tick, rgb} after n edges: the outputs show pixel (n/div)-2
    function automatic logic [14:0] expect_out(input int d, input int n, input logic rv,
                                               input int div);
        int m, q, x, y;
        logic tk;
        if (!rv) return {3'b110, 12'h000};
        m  = n / div;
        tk = tick_exp(n, div);
        if (m < 2) return {2'b11, tk, 12'h000};
        q = m - 2;
        x = q % 800;
        y = (q / 800) % 525;
        return {!(x >= 656 && x <= 751), !(y == 490 || y == 491), tk, colour(d, x, y)};
    endfunction

    task automatic cmp(input string name, input int n, input logic [14:0] got,
                       input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d {hs,vs,tick,rgb} got %b %b %b %h expected %b %b %b %h",
                     name, n, got[14], got[13], got[12], got[11:0],
                     exp[14], exp[13], exp[12], exp[11:0]);
            if (errors >= 40) finish_run();
        end
    endtask

    task automatic lit_check(input int key, input logic [11:0] got);
        checks++;
        if (got !== 12'(lit[key])) begin
            errors++;
            $display("FAIL literal kind=%0d n=%0d got %h expected %h",
                     key % 4, key / 4, got, 12'(lit[key]));
            if (errors >= 40) finish_run();
        end
    endtask

    // Register a literal for the pixel q of dut_m (output appears 2 pixels later)
    task automatic add_lit(input int q, input int kind, input int val);
        lit[(q + 2) * 4 + kind] = val;
    endtask

    // Single compare process: model vs both DUTs every cycle, plus pinned literals
    always @(negedge clk) begin
        if (!done) begin
            logic [14:0] got_m, got_a;
            got_m = {bus_m.hs, bus_m.vs, bus_m.frame_tick, bus_m.r, bus_m.g, bus_m.b};
            got_a = {bus_a.hs, bus_a.vs, bus_a.frame_tick, bus_a.r, bus_a.g, bus_a.b};
            if (!rst_m) clear_shadow(0);
            if (!rst_a) clear_shadow(1);
            cmp("dut_m", n_m, got_m, expect_out(0, n_m, rst_m, 1));
            cmp("dut_a", n_a, got_a, expect_out(1, n_a, rst_a, 4));
            if (rst_m) begin
                if (lit.exists(n_m * 4 + 0)) lit_check(n_m * 4 + 0, got_m[11:0]);
                if (lit.exists(n_m * 4 + 1)) lit_check(n_m * 4 + 1, {11'd0, got_m[14]});
                if (lit.exists(n_m * 4 + 2)) lit_check(n_m * 4 + 2, {11'd0, got_m[13]});
                if (lit.exists(n_m * 4 + 3)) lit_check(n_m * 4 + 3, {11'd0, got_m[12]});
            end
            if (rst_m && tick_exp(n_m, 1))
                take_snapshot(0, bus_m.bird_y, bus_m.pipe1, bus_m.pipe2, bus_m.pipe3,
                              bus_m.coin, bus_m.score);
            if (rst_a && tick_exp(n_a, 4))
                take_snapshot(1, bus_a.bird_y, bus_a.pipe1, bus_a.pipe2, bus_a.pipe3,
                              bus_a.coin, bus_a.score);
        end
    end

    task automatic randomize_main();
        bus_m.bird_y       = 16'($urandom);
        bus_m.bird_y[9:0]  = 10'($urandom_range(0, 490));
        bus_m.pipe1        = $urandom;
        bus_m.pipe1[19:10] = 10'($urandom_range(0, 760));
        bus_m.pipe2        = $urandom;
        bus_m.pipe2[19:10] = 10'($urandom_range(0, 760));
        bus_m.pipe3        = $urandom;
        bus_m.pipe3[19:10] = 10'($urandom_range(0, 760));
        bus_m.coin         = $urandom;
        bus_m.coin[31]     = 1'b1;
        bus_m.coin[19:10]  = 10'($urandom_range(0, 480));
        bus_m.coin[9:0]    = 10'($urandom_range(0, 650));
`ifdef SCORE_OVERLAY_EN
        bus_m.score        = 16'h1234;
`else
        bus_m.score        = 16'($urandom);
`endif
    endtask

    initial begin
        clear_shadow(0);
        clear_shadow(1);
        // Frame 0: all-zero state -> pipe column at x 0..49, bird at gy 0..15, digits "0000"
        add_lit(470 * 800 + 45, 0, 'hFD0);
        add_lit(100 * 800 + 10, 0, 'h0C0);
        add_lit(100 * 800 + 100, 0, 'h4CF);
`ifdef SCORE_OVERLAY_EN
        add_lit(9 * 800 + 13, 0, 'hFFF);
        add_lit(F1 + 9 * 800 + 13, 0, 'hFFF);
        add_lit(F1 + 17 * 800 + 24, 0, 'hFFF);
`else
        add_lit(9 * 800 + 13, 0, 'h0C0);
        add_lit(F1 + 9 * 800 + 13, 0, 'h4CF);
        add_lit(F1 + 17 * 800 + 24, 0, 'h4CF);
`endif
        add_lit(F1 + 9 * 800 + 9, 0, 'h4CF);
        add_lit(655, 1, 1);
        add_lit(656, 1, 0);
        add_lit(751, 1, 0);
        add_lit(752, 1, 1);
        add_lit(489 * 800 + 799, 2, 1);
        add_lit(490 * 800, 2, 0);
        add_lit(491 * 800 + 799, 2, 0);
        add_lit(492 * 800, 2, 1);
        add_lit(SNAP - 3, 3, 0);
        add_lit(SNAP - 2, 3, 1);
        add_lit(SNAP - 1, 3, 0);
        // Frame 1: bird 100, pipe1 gap 100 at x 200 y 150, pipe x 1000, coin under bird
        add_lit(F1 + 375 * 800 + 45, 0, 'hFD0);
        add_lit(F1 + 375 * 800 + 56, 0, 'h4CF);
        add_lit(F1 + 374 * 800 + 48, 0, 'hFD0);
        add_lit(F1 + 329 * 800 + 210, 0, 'h0C0);
        add_lit(F1 + 328 * 800 + 210, 0, 'h4CF);
        add_lit(F1 + 230 * 800 + 210, 0, 'h4CF);
        add_lit(F1 + 229 * 800 + 210, 0, 'h0C0);
        add_lit(F1 + 100 * 800 + 249, 0, 'h0C0);
        add_lit(F1 + 100 * 800 + 250, 0, 'h4CF);
        add_lit(F1 + 100 * 800 + 10, 0, 'h4CF);

        rst_m = 1'b0;
        rst_a = 1'b0;
        randomize_main();
        bus_a.bird_y = '0; bus_a.pipe1 = '0; bus_a.pipe2 = '0; bus_a.pipe3 = '0;
        bus_a.coin   = '0; bus_a.score = '0;
        #102;
        rst_m = 1'b1;
        rst_a = 1'b1;

        // State for frame 1, applied long before the snapshot
        wait (n_m >= 1000);
        @(posedge clk); #1;
        bus_m.bird_y = {6'($urandom), 10'd100};
        bus_m.pipe1  = {4'($urandom), 8'd100, 10'd200, 10'd150};
        bus_m.pipe2  = {12'($urandom), 10'd700, 10'($urandom)};
        bus_m.pipe3  = {12'($urandom), 10'd1000, 10'($urandom)};
        bus_m.coin   = {1'b1, 11'($urandom), 10'd100, 10'd40};
`ifdef SCORE_OVERLAY_EN
        bus_m.score  = 16'h1234;
`else
        bus_m.score  = 16'($urandom);
`endif

        // Mid-frame reset of the divided renderer
        wait (n_a >= 5000);
        @(posedge clk); #3;
        rst_a = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_a = 1'b1;

        // Random state changed mid frame 1 (vc=100); must only appear in frame 2
        wait (n_m >= F1 + 100 * 800);
        @(posedge clk); #1;
        randomize_main();

        wait (n_m >= 2 * FRAME + SNAP + 10);
        @(posedge clk);
        finish_run();
    end

endmodule
